// File: rtl/output_fifo_buffer.sv
// Circular output buffer between the output write controller and the
// downstream consumer. First-word fall-through read port. Occupancy is
// tracked with an explicit count, and full/empty are derived from that
// count. Overflow and underflow are sticky error flags.
module output_fifo_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              w_en,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    input  logic              r_en,
    output logic [DATA_W-1:0] rdata,
    output logic              valid,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic wr_acc;
    logic rd_acc;

    // Status and head-of-buffer word come straight from registered state
    assign ready     = (count_q != FULL_CNT);
    assign valid     = (count_q != '0);
    assign rdata     = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Accept decisions; a flush suppresses both sides for the cycle
    always_comb begin
        wr_acc = w_en & ready & ~clr;
        rd_acc = r_en & valid & ~clr;
    end

    // Next-state for pointers, occupancy and the sticky flags
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
                2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
                default: count_d = count_q;
            endcase
            if (w_en && !ready) begin
                overflow_d = 1'b1;
            end
            if (r_en && !valid) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control state register with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_output_fifo_buffer.sv
// Directed self-checking bench for output_fifo_buffer (DEPTH=8, DATA_W=16).
module tb_output_fifo_buffer;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        w_en;
    logic [15:0] wdata;
    logic        ready;
    logic        r_en;
    logic [15:0] rdata;
    logic        valid;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;

    int unsigned total;
    int unsigned passed;

    output_fifo_buffer #(
        .DATA_W(16),
        .DEPTH (8),
        .ADDR_W(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .w_en     (w_en),
        .wdata    (wdata),
        .ready    (ready),
        .r_en     (r_en),
        .rdata    (rdata),
        .valid    (valid),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, clock it in, sample 1 time unit after the edge
    task automatic step(input logic we, input logic [15:0] wd, input logic re, input logic cl);
        w_en  = we;
        wdata = wd;
        r_en  = re;
        clr   = cl;
        @(posedge clk);
        #1;
        w_en  = 1'b0;
        r_en  = 1'b0;
        clr   = 1'b0;
        wdata = '0;
    endtask

    task automatic pop_check(input string tag, input logic [15:0] exp);
        check({tag, "_valid"}, 32'(valid), 1);
        check({tag, "_rdata"}, 32'(rdata), 32'(exp));
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        clr    = 1'b0;
        w_en   = 1'b0;
        r_en   = 1'b0;
        wdata  = '0;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        check("rst_ready", 32'(ready), 1);
        check("rst_valid", 32'(valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf",   32'(overflow), 0);
        check("rst_unf",   32'(underflow), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three writes, no reads
        step(1'b1, 16'h0011, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 1'b0, 1'b0);
        step(1'b1, 16'h0033, 1'b0, 1'b0);
        check("w3_count", 32'(count), 3);
        check("w3_valid", 32'(valid), 1);
        check("w3_rdata", 32'(rdata), 'h0011);
        check("w3_ready", 32'(ready), 1);
        check("w3_ovf",   32'(overflow), 0);
        check("w3_unf",   32'(underflow), 0);
        pop_check("w3_pop0", 16'h0011);
        pop_check("w3_pop1", 16'h0022);
        pop_check("w3_pop2", 16'h0033);
        check("w3_empty", 32'(valid), 0);

        // Fill to full, then a rejected write
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        check("full_ready", 32'(ready), 0);
        check("full_count", 32'(count), 8);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        check("full_ovf",   32'(overflow), 1);
        check("full_count2", 32'(count), 8);
        for (int i = 0; i < 8; i++) pop_check("full_pop", 16'h0100 + 16'(i));
        check("full_drained_valid", 32'(valid), 0);
        check("full_drained_count", 32'(count), 0);
        check("ovf_sticky", 32'(overflow), 1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("clr_ovf", 32'(overflow), 0);

        // Wrap-around: pointers start at 0, second batch occupies 6,7,0..3
        for (int i = 0; i < 6; i++) step(1'b1, 16'h0900 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) pop_check("wrap_a", 16'h0900 + 16'(i));
        for (int i = 0; i < 6; i++) step(1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0);
        check("wrap_count", 32'(count), 6);
        for (int i = 0; i < 6; i++) pop_check("wrap_b", 16'h0A00 + 16'(i));
        check("wrap_end_count", 32'(count), 0);

        // Partially filled, push and pop together
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0B00 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("both_rdata", 32'(rdata), (i < 4) ? 32'h0B00 + 32'(i) : 32'h0C00);
            step(1'b1, 16'h0C00 + 16'(i), 1'b1, 1'b0);
            check("both_count", 32'(count), 4);
        end
        for (int i = 0; i < 4; i++) pop_check("both_tail", 16'h0C01 + 16'(i));

        // Full with push and pop together: only the pop is taken
        for (int i = 0; i < 8; i++) step(1'b1, 16'h0D00 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);
        check("fullboth_count", 32'(count), 7);
        check("fullboth_ovf",   32'(overflow), 1);
        for (int i = 0; i < 7; i++) pop_check("fullboth_pop", 16'h0D01 + 16'(i));
        check("fullboth_empty", 32'(valid), 0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Empty with push and pop together: only the push is taken
        step(1'b1, 16'h0E0E, 1'b1, 1'b0);
        check("emptyboth_count", 32'(count), 1);
        check("emptyboth_unf",   32'(underflow), 1);
        check("emptyboth_rdata", 32'(rdata), 'h0E0E);
        check("emptyboth_valid", 32'(valid), 1);

        // Fresh reset, read on empty, then clr with a same-cycle write
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);
        check("rdempty_unf",   32'(underflow), 1);
        check("rdempty_count", 32'(count), 0);
        step(1'b1, 16'h5555, 1'b0, 1'b1);
        check("clrw_count", 32'(count), 0);
        check("clrw_unf",   32'(underflow), 0);
        check("clrw_ovf",   32'(overflow), 0);
        check("clrw_valid", 32'(valid), 0);

        // Asynchronous reset in the middle of a cycle at count=5
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0F00 + 16'(i), 1'b0, 1'b0);
        check("mid_count", 32'(count), 5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(ready), 1);
        check("arst_valid", 32'(valid), 0);
        check("arst_count", 32'(count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 16'h7777, 1'b0, 1'b0);
        check("post_rst_rdata", 32'(rdata), 'h7777);
        check("post_rst_count", 32'(count), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
